// File: rtl/mux_tree_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_tree_pkg
// Brief    : Shared sizing helpers for the pipelined radix-4 selector tree.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_tree_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_N     = 32;
  localparam int DEF_TAG_W = 4;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SEL_W = sel_width(DEF_N);

  function automatic int tree_levels(input int n);
    return (sel_width(n) + 1) / 2;
  endfunction

  // Only the final level can be 2:1, and only for an odd select width.
  function automatic int level_fanin(input int n, input int k);
    if ((k == tree_levels(n)) && ((sel_width(n) % 2) == 1)) return 2;
    return 4;
  endfunction

  function automatic int fanin_bits(input int radix);
    return (radix == 4) ? 2 : 1;
  endfunction

  function automatic int sel_rest_width(input int sel_in_w, input int radix);
    int rest;
    rest = sel_in_w - fanin_bits(radix);
    return (rest > 0) ? rest : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_tree_pipe_if.sv
//------------------------------------------------------------------------------
// Module   : mux_tree_pipe_if
// Brief    : Request/response bundle of the selector pipe.
//            MUX_TREE_PIPE_TAG_EN adds the in_tag/out_tag sideband.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_tree_pipe_if #(
  parameter int WIDTH = mux_tree_pkg::DEF_WIDTH,
  parameter int N     = mux_tree_pkg::DEF_N,
  parameter int TAG_W = mux_tree_pkg::DEF_TAG_W
);
  import mux_tree_pkg::*;

  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [sel_width(N)-1:0]       in_sel;
  logic [N-1:0][WIDTH-1:0]       in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
`ifdef MUX_TREE_PIPE_TAG_EN
  logic [TAG_W-1:0]              in_tag;
  logic [TAG_W-1:0]              out_tag;
`endif

  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
`ifdef MUX_TREE_PIPE_TAG_EN
    output in_tag,
    input  out_tag,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
`ifdef MUX_TREE_PIPE_TAG_EN
    input  in_tag,
    output out_tag,
`endif
    output in_ready, out_valid, out_data
  );

endinterface

`default_nettype wire

// File: rtl/mux_tree_pipe_level.sv
//------------------------------------------------------------------------------
// Module   : mux_tree_level
// Brief    : One 4:1 or 2:1 reduction of a word vector plus its pipeline
//            register and load logic. MUX_TREE_PIPE_TAG_EN adds a tag register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IN_WORDS = 4,
  parameter int RADIX    = 4,
  parameter int SEL_IN_W = 2,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          flush,
  input  logic                                          i_valid,
  input  logic [IN_WORDS-1:0][WIDTH-1:0]                i_data,
  input  logic [SEL_IN_W-1:0]                           i_sel,
`ifdef MUX_TREE_PIPE_TAG_EN
  input  logic [TAG_W-1:0]                              i_tag,
  output logic [TAG_W-1:0]                              o_tag,
`endif
  input  logic                                          i_next_load,
  output logic                                          o_load,
  output logic                                          o_valid,
  output logic [IN_WORDS/RADIX-1:0][WIDTH-1:0]          o_data,
  output logic [sel_rest_width(SEL_IN_W, RADIX)-1:0]    o_sel
);

  localparam int C_OUT_WORDS = IN_WORDS / RADIX;
  localparam int C_PICK_W    = fanin_bits(RADIX);
  localparam int C_REST_W    = SEL_IN_W - C_PICK_W;
  localparam int C_SEL_REG_W = sel_rest_width(SEL_IN_W, RADIX);

  logic [C_OUT_WORDS-1:0][RADIX-1:0][WIDTH-1:0] w_grp;
  logic [C_OUT_WORDS-1:0][WIDTH-1:0]            w_mux;
  logic [C_PICK_W-1:0]                          w_pick;
  logic [C_SEL_REG_W-1:0]                       w_rest;
  logic                                         w_load;
  logic                                         w_take;

  logic                                         r_valid;
  logic [C_OUT_WORDS-1:0][WIDTH-1:0]            r_data;
  logic [C_SEL_REG_W-1:0]                       r_sel;

  // Regrouping the flat vector makes each output word pick among RADIX neighbours.
  assign w_grp  = i_data;
  assign w_pick = i_sel[C_PICK_W-1:0];

  always_comb begin
    w_mux = '0;
    for (int j = 0; j < C_OUT_WORDS; j++) begin
      w_mux[j] = w_grp[j][w_pick];
    end
  end

  generate
    if (C_REST_W > 0) begin : g_rest
      assign w_rest = i_sel[SEL_IN_W-1:C_PICK_W];
    end else begin : g_no_rest
      assign w_rest = '0;
    end
  endgenerate

  assign w_load = !r_valid || i_next_load;
  assign w_take = w_load && i_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= i_valid;
      end
      if (w_take) begin
        r_data <= w_mux;
        r_sel  <= w_rest;
      end
    end
  end

`ifdef MUX_TREE_PIPE_TAG_EN
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag <= '0;
    end else if (w_take) begin
      r_tag <= i_tag;
    end
  end

  assign o_tag = r_tag;
`endif

  assign o_load  = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule

`default_nettype wire

// File: rtl/mux_tree_pipe.sv
//------------------------------------------------------------------------------
// Module   : mux_tree_pipe
// Brief    : Pipelined N:1 word selector, radix-4 tree, valid/ready per level.
//            MUX_TREE_PIPE_TAG_EN carries a sideband tag with each request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic            clk,
  input  logic            reset_n,
  mux_tree_pipe_if.slave  bus
);

  localparam int C_SEL_W  = sel_width(N);
  localparam int C_LEVELS = tree_levels(N);

  // Holds in_ready low during reset and for the first edge after release.
  logic r_alive;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  generate
    for (genvar k = 1; k <= C_LEVELS; k++) begin : g_lvl
      localparam int C_IN_WORDS  = N >> (2 * (k - 1));
      localparam int C_RADIX     = level_fanin(N, k);
      localparam int C_SEL_IN_W  = C_SEL_W - 2 * (k - 1);
      localparam int C_OUT_WORDS = C_IN_WORDS / C_RADIX;
      localparam int C_SEL_OUT_W = sel_rest_width(C_SEL_IN_W, C_RADIX);

      logic                                  w_in_valid;
      logic [C_IN_WORDS-1:0][WIDTH-1:0]      w_in_data;
      logic [C_SEL_IN_W-1:0]                 w_in_sel;
      logic                                  w_next_load;
      logic                                  w_load;
      logic                                  w_valid;
      logic [C_OUT_WORDS-1:0][WIDTH-1:0]     w_data;
      logic [C_SEL_OUT_W-1:0]                w_sel;
`ifdef MUX_TREE_PIPE_TAG_EN
      logic [TAG_W-1:0]                      w_in_tag;
      logic [TAG_W-1:0]                      w_tag;
`endif

      if (k == 1) begin : g_first
        assign w_in_valid = bus.in_valid && r_alive && !bus.flush;
        assign w_in_data  = bus.in_data;
        assign w_in_sel   = bus.in_sel;
`ifdef MUX_TREE_PIPE_TAG_EN
        assign w_in_tag   = bus.in_tag;
`endif
      end else begin : g_chain
        assign w_in_valid = g_lvl[k-1].w_valid;
        assign w_in_data  = g_lvl[k-1].w_data;
        assign w_in_sel   = g_lvl[k-1].w_sel;
`ifdef MUX_TREE_PIPE_TAG_EN
        assign w_in_tag   = g_lvl[k-1].w_tag;
`endif
      end

      // Stall chain: each level frees up when it is empty or its successor loads.
      if (k == C_LEVELS) begin : g_last
        assign w_next_load = !w_valid || bus.out_ready;
      end else begin : g_inner
        assign w_next_load = g_lvl[k+1].w_load;
      end

      mux_tree_level #(
        .WIDTH    (WIDTH),
        .IN_WORDS (C_IN_WORDS),
        .RADIX    (C_RADIX),
        .SEL_IN_W (C_SEL_IN_W),
        .TAG_W    (TAG_W)
      ) u_level (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (bus.flush),
        .i_valid     (w_in_valid),
        .i_data      (w_in_data),
        .i_sel       (w_in_sel),
`ifdef MUX_TREE_PIPE_TAG_EN
        .i_tag       (w_in_tag),
        .o_tag       (w_tag),
`endif
        .i_next_load (w_next_load),
        .o_load      (w_load),
        .o_valid     (w_valid),
        .o_data      (w_data),
        .o_sel       (w_sel)
      );
    end
  endgenerate

  assign bus.in_ready  = r_alive && g_lvl[1].w_load && !bus.flush;
  assign bus.out_valid = g_lvl[C_LEVELS].w_valid;
  assign bus.out_data  = g_lvl[C_LEVELS].w_data[0];
`ifdef MUX_TREE_PIPE_TAG_EN
  assign bus.out_tag   = g_lvl[C_LEVELS].w_tag;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_tree_pipe
// Brief    : Directed bench for mux_tree_pipe at N=32, N=2 and N=256.
//            With MUX_TREE_PIPE_TAG_EN the returned tag is checked as well.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_tree_pipe;
  import mux_tree_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mux_tree_pipe_if #(.WIDTH(64), .N(32),  .TAG_W(4)) bus ();
  mux_tree_pipe_if #(.WIDTH(16), .N(2),   .TAG_W(4)) b2 ();
  mux_tree_pipe_if #(.WIDTH(16), .N(256), .TAG_W(4)) b256 ();

  mux_tree_pipe #(.WIDTH(64), .N(32),  .TAG_W(4)) u_dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  mux_tree_pipe #(.WIDTH(16), .N(2),   .TAG_W(4)) u_n2   (.clk(clk), .reset_n(reset_n), .bus(b2));
  mux_tree_pipe #(.WIDTH(16), .N(256), .TAG_W(4)) u_n256 (.clk(clk), .reset_n(reset_n), .bus(b256));

  typedef logic [31:0][63:0] word_vec_t;
  typedef struct { int pat; int sel; logic [63:0] exp; } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[12];
  int   issued, got, acc0, last, acc, seen, n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic word_vec_t mk(input int pat);
    word_vec_t v;
    for (int i = 0; i < 32; i++) begin
      case (pat)
        0:       v[i] = 64'(i);
        1:       v[i] = (i > 15) ? 64'd1 : 64'd0;
        default: v[i] = (i % 3 == 1) ? 64'd1 : 64'd0;
      endcase
    end
    return v;
  endfunction

  // One isolated request; input data is scrambled right after acceptance.
  task automatic run_one(input int pat, input int sel, input logic [63:0] exp, input string nm);
    int k;
    bus.in_data  = mk(pat);
    bus.in_sel   = 5'(sel);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
`ifdef MUX_TREE_PIPE_TAG_EN
    bus.in_tag = 4'(sel ^ 5);
`endif
    #1;
    k = 0;
    while (!bus.in_ready && k < 10) begin step(); k++; end
    chk({nm, "_acc"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = ~mk(pat);
    k = 0;
    while (!bus.out_valid && k < 10) begin step(); k++; end
    chk({nm, "_v"}, 64'(bus.out_valid), 64'd1);
    chk(nm, bus.out_data, exp);
`ifdef MUX_TREE_PIPE_TAG_EN
    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(4'(sel ^ 5)));
`endif
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 5,  64'd5};
    vecs[1]  = '{0, 31, 64'd31};
    vecs[2]  = '{0, 0,  64'd0};
    vecs[3]  = '{1, 15, 64'd0};
    vecs[4]  = '{1, 16, 64'd1};
    vecs[5]  = '{1, 31, 64'd1};
    vecs[6]  = '{1, 0,  64'd0};
    vecs[7]  = '{2, 1,  64'd1};
    vecs[8]  = '{2, 4,  64'd1};
    vecs[9]  = '{2, 30, 64'd0};
    vecs[10] = '{2, 31, 64'd1};
    vecs[11] = '{2, 2,  64'd0};

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    b2.flush = 1'b0; b2.in_valid = 1'b0; b2.in_sel = '0; b2.out_ready = 1'b1;
    b256.flush = 1'b0; b256.in_valid = 1'b0; b256.in_sel = '0; b256.out_ready = 1'b1;
`ifdef MUX_TREE_PIPE_TAG_EN
    bus.in_tag = '0; b2.in_tag = '0; b256.in_tag = '0;
`endif
    for (int i = 0; i < 2; i++)   b2.in_data[i]   = 16'(i * 3);
    for (int i = 0; i < 256; i++) b256.in_data[i] = 16'(i * 3);

    // Reset state
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    chk("rel_ready", 64'(bus.in_ready), 64'd1);

    // Streaming sel 0..31, identity data
    issued = 0; got = 0; acc0 = -1; last = -1;
    bus.in_data = mk(0);
    for (int cyc = 0; cyc < 80 && got < 32; cyc++) begin
      if (bus.out_valid) begin
        chk("strm_data", bus.out_data, 64'(got));
        if (got == 0) chk("strm_lat", 64'(cyc - acc0), 64'd3);
        last = cyc;
        got++;
      end
      bus.in_valid = (issued < 32);
      bus.in_sel   = 5'(issued);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (issued == 0) acc0 = cyc;
        issued++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("strm_count", 64'(got), 64'd32);
    chk("strm_rate", 64'(last - acc0), 64'd34);

    // Table vectors, then full sweeps of the two boolean patterns
    for (int i = 0; i < 12; i++)
      run_one(vecs[i].pat, vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
    for (int p = 1; p <= 2; p++)
      for (int s = 0; s < 32; s++)
        run_one(p, s, (p == 1) ? 64'(s > 15) : 64'(s % 3 == 1), $sformatf("sweep_p%0d_s%0d", p, s));

    // Backpressure: consumer stalled for 5 cycles
    bus.in_data = mk(0); bus.out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'(10 + acc);
      #1;
      if (bus.in_ready) acc++;
      step();
      if (bus.out_valid) chk("bp_hold", bus.out_data, 64'd10);
    end
    chk("bp_acc", 64'(acc), 64'd3);
    chk("bp_full", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1; got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (bus.out_valid) begin
        chk("bp_drain", bus.out_data, 64'(10 + got));
        got++;
      end
      bus.in_valid = (acc < 6);
      bus.in_sel   = 5'(10 + acc);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd6);

    // Flush with three transactions in flight
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'(20 + c);
      step();
    end
    bus.in_sel = 5'd25;
    bus.flush  = 1'b1;
    #1;
    chk("fl_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_ovalid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1; seen = 0;
    repeat (6) begin step(); if (bus.out_valid) seen++; end
    chk("fl_ghost", 64'(seen), 64'd0);
    bus.in_valid = 1'b1; bus.in_sel = 5'd7;
    step();
    bus.in_valid = 1'b0; n = 1;
    while (!bus.out_valid && n < 10) begin step(); n++; end
    chk("fl_lat", 64'(n), 64'd3);
    chk("fl_data", bus.out_data, 64'd7);
    step();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 5'd9;  step();
    bus.in_sel = 5'd12; step();
    bus.in_valid = 1'b0; step();
    chk("ar_pre", bus.out_data, 64'd9);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_data", bus.out_data, 64'd0);
    chk("ar_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    chk("ar_rel_ready", 64'(bus.in_ready), 64'd1);
    run_one(0, 19, 64'd19, "ar_resume");

    // N=2: single 2:1 level
    step();
    issued = 0; got = 0; acc0 = -1;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      if (b2.out_valid) begin
        chk("n2_data", 64'(b2.out_data), 64'(got * 3));
        if (got == 0) chk("n2_lat", 64'(cyc - acc0), 64'd1);
        got++;
      end
      b2.in_valid = (issued < 2);
      b2.in_sel   = 1'(issued);
      #1;
      if (b2.in_valid && b2.in_ready) begin
        if (issued == 0) acc0 = cyc;
        issued++;
      end
      step();
    end
    b2.in_valid = 1'b0;
    chk("n2_count", 64'(got), 64'd2);

    // N=256: four radix-4 levels
    issued = 0; got = 0; acc0 = -1;
    for (int cyc = 0; cyc < 300 && got < 256; cyc++) begin
      if (b256.out_valid) begin
        chk("n256_data", 64'(b256.out_data), 64'(got * 3));
        if (got == 0) chk("n256_lat", 64'(cyc - acc0), 64'd4);
        got++;
      end
      b256.in_valid = (issued < 256);
      b256.in_sel   = 8'(issued);
      #1;
      if (b256.in_valid && b256.in_ready) begin
        if (issued == 0) acc0 = cyc;
        issued++;
      end
      step();
    end
    b256.in_valid = 1'b0;
    chk("n256_count", 64'(got), 64'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
